// File: rtl/const_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : const_bank_pkg
//  Description : Shared types and helpers for the constant source bank.
//                - state_t      : controller state encoding (IDLE/LATCH/RAMP)
//                - ext_t        : wide working type for ramp arithmetic
//                - clog2        : constant-evaluable ceil(log2(n))
//                - step_toward  : next output value moving toward a target
//  Revision    : 1.0  initial release
// ============================================================================
package const_bank_pkg;

    // Widest channel supported. Ramp arithmetic is carried one bit wider so
    // that adding a step can never wrap back into range.
    localparam int MAX_W = 32;

    typedef logic [MAX_W:0] ext_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        RAMP  = 2'd2
    } state_t;

    // ceil(log2(n)); returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Move cur toward tgt by at most step, never past tgt.
    // step == 0 means "jump straight to the target".
    function automatic ext_t step_toward(input ext_t cur, input ext_t tgt,
                                         input ext_t step);
        ext_t d;
        ext_t s;
        d = (tgt > cur) ? (tgt - cur) : (cur - tgt);
        s = ((step == '0) || (step > d)) ? d : step;
        return (tgt > cur) ? (cur + s) : (cur - s);
    endfunction

endpackage : const_bank_pkg
`default_nettype wire

// File: rtl/const_ramp_lane.sv
`default_nettype none
// ============================================================================
//  Module      : const_ramp_lane
//  Description : One channel of the constant source bank. Holds the shadow,
//                target and output registers for a single lane.
//  Ports       : clk, rst       clock / synchronous active-high reset
//                i_wr_en        load i_wr_data into the shadow register
//                i_wr_data      new shadow value
//                i_latch        copy shadow into target
//                i_step_en      advance output one step toward target
//                o_out          current output level
//                o_at_target    output equals target (combinational)
//                o_done_next    output will equal target after this step
//  Revision    : 1.0  initial release
// ============================================================================
module const_ramp_lane
    import const_bank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0,
    parameter int STEP      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_latch,
    input  logic             i_step_en,
    output logic [WIDTH-1:0] o_out,
    output logic             o_at_target,
    output logic             o_done_next
);

    typedef logic [WIDTH-1:0] lane_t;

    localparam lane_t c_reset = lane_t'(RESET_VAL);

    lane_t r_shadow;
    lane_t r_target;
    lane_t r_out;
    lane_t w_next;

    // The wide result is always within [0, 2^WIDTH-1] because it lies between
    // r_out and r_target, so the truncation is lossless.
    assign w_next = lane_t'(step_toward(ext_t'(r_out), ext_t'(r_target),
                                        ext_t'(STEP)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= c_reset;
            r_target <= c_reset;
            r_out    <= c_reset;
        end else begin
            if (i_wr_en) begin
                r_shadow <= i_wr_data;
            end
            // Target samples the shadow value from before this edge, so a
            // write in the same cycle lands only in the shadow.
            if (i_latch) begin
                r_target <= r_shadow;
            end
            if (i_step_en) begin
                r_out <= w_next;
            end
        end
    end

    assign o_out       = r_out;
    assign o_at_target = (r_out == r_target);
    assign o_done_next = (w_next == r_target);

endmodule : const_ramp_lane
`default_nettype wire

// File: rtl/const_source_bank.sv
`default_nettype none
// ============================================================================
//  Module      : const_source_bank
//  Description : Multi-channel programmable constant source. Writes go to
//                per-channel shadow registers; a commit pulse retargets all
//                channels at once and outputs either jump (STEP=0) or slew by
//                STEP per clock toward the new targets.
//  Ports       : clk, rst       clock / synchronous active-high reset
//                wr_valid       write request
//                wr_ready       write accepted (low only while latching)
//                wr_addr        channel index; out-of-range writes are dropped
//                wr_data        new shadow value
//                commit         shadow -> target for all channels
//                busy           latching or ramping
//                out_val        channel i at [i*WIDTH +: WIDTH]
//                at_target      per-channel output == target
//  Revision    : 1.0  initial release
// ============================================================================
module const_source_bank
    import const_bank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int RESET_VAL = 0,
    parameter int STEP      = 1,
    parameter int AW        = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      commit,
    output logic                      busy,
    output logic [CHANNELS*WIDTH-1:0] out_val,
    output logic [CHANNELS-1:0]       at_target
);

    localparam bit c_jump = (STEP == 0);

    state_t              r_state;
    logic                r_busy;

    logic                w_wr_fire;
    logic                w_latch;
    logic                w_step_en;
    logic                w_all_done;
    logic [CHANNELS-1:0] w_done_next;

    assign wr_ready  = (r_state != LATCH);
    assign w_wr_fire = wr_valid && wr_ready;

    // Commit is honoured from IDLE and RAMP; in LATCH it is ignored.
    assign w_latch = commit && ((r_state == IDLE) || (r_state == RAMP));

    // Jump mode updates outputs on the LATCH edge. Ramp mode steps in RAMP,
    // except on a retarget edge, where the output holds so the new ramp
    // starts from the value that was visible when commit was seen.
    assign w_step_en = c_jump ? (r_state == LATCH)
                              : ((r_state == RAMP) && !commit);

    assign w_all_done = &w_done_next;

    // ------------------------------------------------------------------
    // Lanes
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
            logic w_wr_en;

            // Addresses >= CHANNELS match no lane, so the write is
            // accepted and silently dropped.
            assign w_wr_en = w_wr_fire && (wr_addr == AW'(i));

            const_ramp_lane #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL),
                .STEP      (STEP)
            ) u_lane (
                .clk         (clk),
                .rst         (rst),
                .i_wr_en     (w_wr_en),
                .i_wr_data   (wr_data),
                .i_latch     (w_latch),
                .i_step_en   (w_step_en),
                .o_out       (out_val[i*WIDTH +: WIDTH]),
                .o_at_target (at_target[i]),
                .o_done_next (w_done_next[i])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (commit) begin
                        r_state <= LATCH;
                        r_busy  <= 1'b1;
                    end
                end
                LATCH: begin
                    if (c_jump) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= RAMP;
                        r_busy  <= 1'b1;
                    end
                end
                RAMP: begin
                    if (commit) begin
                        r_state <= LATCH;
                        r_busy  <= 1'b1;
                    end else if (w_all_done) begin
                        // Leave on the same edge that lands the last step.
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;

endmodule : const_source_bank
`default_nettype wire

// File: tb/tb_const_source_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_const_source_bank
//  Description : Directed self-checking bench. Several instances with
//                different STEP / CHANNELS settings share one stimulus set;
//                each scenario resets everything and checks one instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_const_source_bank;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [1:0] wr_addr;
    logic [2:0] wr_addr5;
    logic [7:0] wr_data;
    logic       commit;

    logic        s0_ready, s0_busy;  logic [31:0] s0_out;  logic [3:0] s0_at;
    logic        s1_ready, s1_busy;  logic [31:0] s1_out;  logic [3:0] s1_at;
    logic        s3_ready, s3_busy;  logic [31:0] s3_out;  logic [3:0] s3_at;
    logic        s4_ready, s4_busy;  logic [31:0] s4_out;  logic [3:0] s4_at;
    logic        c5_ready, c5_busy;  logic [39:0] c5_out;  logic [4:0] c5_at;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    const_source_bank #(.WIDTH(8), .CHANNELS(4), .RESET_VAL(0), .STEP(0)) u_s0 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(s0_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .busy(s0_busy), .out_val(s0_out), .at_target(s0_at));

    const_source_bank #(.WIDTH(8), .CHANNELS(4), .RESET_VAL(0), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(s1_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .busy(s1_busy), .out_val(s1_out), .at_target(s1_at));

    const_source_bank #(.WIDTH(8), .CHANNELS(4), .RESET_VAL(0), .STEP(3)) u_s3 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(s3_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .busy(s3_busy), .out_val(s3_out), .at_target(s3_at));

    const_source_bank #(.WIDTH(8), .CHANNELS(4), .RESET_VAL(0), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(s4_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .busy(s4_busy), .out_val(s4_out), .at_target(s4_at));

    const_source_bank #(.WIDTH(8), .CHANNELS(5), .RESET_VAL(0), .STEP(0)) u_c5 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(c5_ready),
        .wr_addr(wr_addr5), .wr_data(wr_data), .commit(commit),
        .busy(c5_busy), .out_val(c5_out), .at_target(c5_at));

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst      = 1'b1;
        wr_valid = 1'b0;
        commit   = 1'b0;
        wr_addr  = '0;
        wr_addr5 = '0;
        wr_data  = '0;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        int  n;
        bit  wrapped;
        logic [7:0] prev;

        // ---------------- 1: reset ----------------
        do_reset(3);
        check("rst_out",    s0_out,   32'h0);
        check("rst_busy",   s0_busy,  1'b0);
        check("rst_at",     s0_at,    4'hF);
        check("rst_ready",  s0_ready, 1'b1);
        check("rst_out_s4", s4_out,   32'h0);

        // ---------------- 2: STEP=0 jump ----------------
        wr(2'd2, 8'hA5);
        check("jump_pre_commit", s0_out, 32'h0);
        pulse_commit();
        check("jump_latch_out",   s0_out,   32'h0);
        check("jump_latch_busy",  s0_busy,  1'b1);
        check("jump_latch_ready", s0_ready, 1'b0);
        tick();
        check("jump_out",  s0_out,  32'h00A5_0000);
        check("jump_busy", s0_busy, 1'b0);
        check("jump_at",   s0_at,   4'hF);

        // ---------------- 3: STEP=4 ramp up/down ----------------
        do_reset(2);
        wr(2'd0, 8'h0A);
        pulse_commit();
        check("r4_latch", s4_out, 32'h0);
        tick();
        check("r4_hold",  s4_out, 32'h0);
        check("r4_at",    s4_at,  4'hE);
        tick();
        check("r4_up1",   s4_out, 32'h04);
        tick();
        check("r4_up2",   s4_out, 32'h08);
        check("r4_busy2", s4_busy, 1'b1);
        tick();
        check("r4_up3",   s4_out, 32'h0A);
        check("r4_done",  s4_busy, 1'b0);
        check("r4_at_done", s4_at, 4'hF);
        wr(2'd0, 8'h00);
        pulse_commit();
        tick();
        check("r4_dn_hold", s4_out, 32'h0A);
        tick();
        check("r4_dn1", s4_out, 32'h06);
        tick();
        check("r4_dn2", s4_out, 32'h02);
        tick();
        check("r4_dn3",    s4_out,  32'h00);
        check("r4_dn_done", s4_busy, 1'b0);

        // ---------------- 4: retarget mid-ramp ----------------
        do_reset(2);
        wr(2'd1, 8'h10);
        pulse_commit();
        tick();
        check("rt_start", s1_out, 32'h0);
        wr(2'd1, 8'h02);                    // shadow only; ramp continues
        check("rt_s1", s1_out, 32'h0000_0100);
        check("rt_ready_ramp", s1_ready, 1'b1);
        tick(); tick(); tick(); tick();
        check("rt_at5", s1_out, 32'h0000_0500);
        pulse_commit();
        check("rt_latch",      s1_out,   32'h0000_0500);
        check("rt_latch_rdy",  s1_ready, 1'b0);
        tick();
        check("rt_hold", s1_out, 32'h0000_0500);
        tick();
        check("rt_4", s1_out, 32'h0000_0400);
        tick();
        check("rt_3", s1_out, 32'h0000_0300);
        check("rt_busy3", s1_busy, 1'b1);
        tick();
        check("rt_2",    s1_out,  32'h0000_0200);
        check("rt_idle", s1_busy, 1'b0);

        // ---------------- 5: same-cycle write + commit ----------------
        do_reset(2);
        wr(2'd3, 8'h11);
        wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 8'h22; commit = 1'b1;
        tick();
        wr_valid = 1'b0; commit = 1'b0;
        tick();
        check("swc_first",  s0_out, 32'h1100_0000);
        pulse_commit();
        tick();
        check("swc_second", s0_out, 32'h2200_0000);

        do_reset(2);
        wr_valid = 1'b1; wr_addr5 = 3'd5; wr_data = 8'h77;
        tick();
        wr_addr5 = 3'd4; wr_data = 8'h33;
        tick();
        wr_valid = 1'b0;
        pulse_commit();
        tick();
        check("oob_drop", c5_out, 40'h33_0000_0000);
        check("oob_at",   c5_at,  5'h1F);

        // ---------------- 6: reset mid-ramp, no wrap ----------------
        do_reset(2);
        wr(2'd0, 8'hFF);
        pulse_commit();
        tick();
        for (int i = 0; i < 8'h40; i++) tick();
        check("mr_at40", s1_out, 32'h40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_out",  s1_out,  32'h0);
        check("mr_busy", s1_busy, 1'b0);
        check("mr_at",   s1_at,   4'hF);

        do_reset(2);
        wr(2'd0, 8'hFF);
        pulse_commit();
        n = 0; wrapped = 1'b0; prev = 8'h00;
        while (s3_busy && n < 400) begin
            tick();
            if (s3_out[7:0] < prev) wrapped = 1'b1;
            prev = s3_out[7:0];
            n++;
        end
        check("b3_timeout_up", (n < 400), 1'b1);
        check("b3_top",     s3_out, 32'h0000_00FF);
        check("b3_no_wrap", wrapped, 1'b0);

        wr(2'd0, 8'h01);
        pulse_commit();
        n = 0; wrapped = 1'b0; prev = 8'hFF;
        while (s3_busy && n < 400) begin
            tick();
            if (s3_out[7:0] > prev) wrapped = 1'b1;
            prev = s3_out[7:0];
            n++;
        end
        check("b3_timeout_dn", (n < 400), 1'b1);
        check("b3_bottom",     s3_out, 32'h0000_0001);
        check("b3_no_wrap_dn", wrapped, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_const_source_bank
`default_nettype wire
